// File: rtl/rename_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rename_stage
//  Description : Register renamer sitting between decode and the ROB/issue
//                path. Holds the architectural-to-physical alias table (RAT)
//                and a circular FIFO free list of physical register numbers.
//                Sources are translated through the RAT, each renamed
//                destination pops a fresh PRN, and PRNs released by commit
//                are pushed back at the tail every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rename_stage #(
    parameter int PRN_BITS     = 6,
    parameter int ARN_COUNT    = 32,
    parameter int ZERO_ARN     = 31,
    parameter int MAX_OPERANDS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [63:0]         in_pc,
    input  logic                in_op_valid   [MAX_OPERANDS],
    input  logic                in_op_is_dest [MAX_OPERANDS],
    input  logic [5:0]          in_op_arn     [MAX_OPERANDS],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_pc,
    output logic                out_op_valid  [MAX_OPERANDS],
    output logic [PRN_BITS-1:0] out_op_prn    [MAX_OPERANDS],
    output logic                out_old_valid [MAX_OPERANDS],
    output logic [PRN_BITS-1:0] out_old_prn   [MAX_OPERANDS],
    output logic [5:0]          out_old_arn   [MAX_OPERANDS],
    input  logic                freed_valid   [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0] freed_prn     [MAX_OPERANDS],
    output logic [PRN_BITS:0]   free_count
);

    typedef logic [PRN_BITS-1:0] prn_t;
    typedef logic [PRN_BITS:0]   cnt_t;
    typedef logic [PRN_BITS+1:0] wide_t;
    typedef logic [5:0]          arn_t;

    localparam int    c_NUM_PRN      = 1 << PRN_BITS;
    localparam int    c_RAT_IDX_BITS = $clog2(ARN_COUNT);
    localparam arn_t  c_ZERO_ARN     = arn_t'(ZERO_ARN);
    localparam cnt_t  c_RESET_FREE   = cnt_t'(c_NUM_PRN - ARN_COUNT);
    localparam prn_t  c_RESET_HEAD   = prn_t'(ARN_COUNT);
    localparam wide_t c_COUNT_LIMIT  = wide_t'(c_NUM_PRN);

    // Architectural state
    prn_t  r_rat [ARN_COUNT];
    prn_t  r_fl  [c_NUM_PRN];
    prn_t  r_head;
    prn_t  r_tail;
    cnt_t  r_free_count;

    // Output register
    logic  r_out_valid;
    logic [63:0] r_out_pc;
    logic  r_out_op_valid  [MAX_OPERANDS];
    prn_t  r_out_op_prn    [MAX_OPERANDS];
    logic  r_out_old_valid [MAX_OPERANDS];
    prn_t  r_out_old_prn   [MAX_OPERANDS];
    arn_t  r_out_old_arn   [MAX_OPERANDS];

    // Combinational rename view
    logic  w_ren      [MAX_OPERANDS];
    prn_t  w_src_prn  [MAX_OPERANDS];
    prn_t  w_pop_prn  [MAX_OPERANDS];
    prn_t  w_push_off [MAX_OPERANDS];
    cnt_t  w_need;
    cnt_t  w_push_cnt;
    wide_t w_count_next;
    logic  w_accept;
    logic  w_dup_dest;

    // Classify slots, look up current mappings and pick free-list entries in slot order
    always_comb begin
        w_need = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            w_ren[i]     = in_op_valid[i] && in_op_is_dest[i] && (in_op_arn[i] != c_ZERO_ARN);
            w_src_prn[i] = r_rat[in_op_arn[i][c_RAT_IDX_BITS-1:0]];
            w_pop_prn[i] = r_fl[r_head + w_need[PRN_BITS-1:0]];
            if (w_ren[i]) begin
                w_need = w_need + cnt_t'(1);
            end
        end
    end

    // Tail offsets for PRNs returned by commit, packed in slot order
    always_comb begin
        w_push_cnt = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            w_push_off[i] = w_push_cnt[PRN_BITS-1:0];
            if (freed_valid[i]) begin
                w_push_cnt = w_push_cnt + cnt_t'(1);
            end
        end
    end

    // Flag two renamed destinations naming the same architectural register
    always_comb begin
        w_dup_dest = 1'b0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            for (int j = i + 1; j < MAX_OPERANDS; j++) begin
                if (w_ren[i] && w_ren[j] && (in_op_arn[i] == in_op_arn[j])) begin
                    w_dup_dest = 1'b1;
                end
            end
        end
    end

    // Allocation only uses the registered occupancy, so same-cycle frees cannot be popped
    assign in_ready     = !rst && (!r_out_valid || out_ready) && (r_free_count >= w_need);
    assign w_accept     = in_valid && in_ready;
    assign w_count_next = {1'b0, r_free_count}
                        - (w_accept ? {1'b0, w_need} : wide_t'(0))
                        + {1'b0, w_push_cnt};

    // RAT updates on accept; free list pops at head and pushes at tail, both wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < ARN_COUNT; a++) begin
                r_rat[a] <= prn_t'(a);
            end
            for (int p = 0; p < c_NUM_PRN; p++) begin
                r_fl[p] <= prn_t'(p);
            end
            r_head       <= c_RESET_HEAD;
            // Head plus a full list of (NUM_PRN - ARN_COUNT) entries wraps back to zero
            r_tail       <= '0;
            r_free_count <= c_RESET_FREE;
        end else begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (w_accept && w_ren[i]) begin
                    r_rat[in_op_arn[i][c_RAT_IDX_BITS-1:0]] <= w_pop_prn[i];
                end
                if (freed_valid[i]) begin
                    r_fl[r_tail + w_push_off[i]] <= freed_prn[i];
                end
            end
            if (w_accept) begin
                r_head <= r_head + w_need[PRN_BITS-1:0];
            end
            r_tail       <= r_tail + w_push_cnt[PRN_BITS-1:0];
            r_free_count <= w_count_next[PRN_BITS:0];
        end
    end

    // Output register: load on accept, hold while stalled, drop valid after handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                r_out_op_valid[i]  <= 1'b0;
                r_out_op_prn[i]    <= '0;
                r_out_old_valid[i] <= 1'b0;
                r_out_old_prn[i]   <= '0;
                r_out_old_arn[i]   <= '0;
            end
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= in_pc;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                r_out_op_valid[i]  <= in_op_valid[i];
                r_out_old_valid[i] <= w_ren[i];
                if (!in_op_valid[i]) begin
                    r_out_op_prn[i] <= '0;
                end else if (w_ren[i]) begin
                    r_out_op_prn[i] <= w_pop_prn[i];
                end else begin
                    // Sources and zero-register destinations both read the current mapping
                    r_out_op_prn[i] <= w_src_prn[i];
                end
                r_out_old_prn[i] <= w_ren[i] ? w_src_prn[i] : '0;
                r_out_old_arn[i] <= w_ren[i] ? in_op_arn[i] : '0;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_pc        = r_out_pc;
    assign out_op_valid  = r_out_op_valid;
    assign out_op_prn    = r_out_op_prn;
    assign out_old_valid = r_out_old_valid;
    assign out_old_prn   = r_out_old_prn;
    assign out_old_arn   = r_out_old_arn;
    assign free_count    = r_free_count;

    a_no_dup_dest : assert property (@(posedge clk) disable iff (rst)
        !(in_valid && w_dup_dest));

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        w_count_next <= c_COUNT_LIMIT);

endmodule
`default_nettype wire

// File: tb/tb_rename_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rename_stage
//  Description : Directed self-checking bench for rename_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_stage;

    localparam int c_PRN_BITS = 6;
    localparam int c_OPS      = 3;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [63:0]           in_pc;
    logic                  in_op_valid   [c_OPS];
    logic                  in_op_is_dest [c_OPS];
    logic [5:0]            in_op_arn     [c_OPS];
    logic                  out_valid;
    logic                  out_ready;
    logic [63:0]           out_pc;
    logic                  out_op_valid  [c_OPS];
    logic [c_PRN_BITS-1:0] out_op_prn    [c_OPS];
    logic                  out_old_valid [c_OPS];
    logic [c_PRN_BITS-1:0] out_old_prn   [c_OPS];
    logic [5:0]            out_old_arn   [c_OPS];
    logic                  freed_valid   [c_OPS];
    logic [c_PRN_BITS-1:0] freed_prn     [c_OPS];
    logic [c_PRN_BITS:0]   free_count;

    int n_checks;
    int n_fail;
    int n_handoff;

    rename_stage #(
        .PRN_BITS     (c_PRN_BITS),
        .ARN_COUNT    (32),
        .ZERO_ARN     (31),
        .MAX_OPERANDS (c_OPS)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_op_valid   (in_op_valid),
        .in_op_is_dest (in_op_is_dest),
        .in_op_arn     (in_op_arn),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_op_valid  (out_op_valid),
        .out_op_prn    (out_op_prn),
        .out_old_valid (out_old_valid),
        .out_old_prn   (out_old_prn),
        .out_old_arn   (out_old_arn),
        .freed_valid   (freed_valid),
        .freed_prn     (freed_prn),
        .free_count    (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count handoffs to downstream
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_handoff <= n_handoff + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic v0, input logic d0, input logic [5:0] a0,
                           input logic v1, input logic d1, input logic [5:0] a1,
                           input logic v2, input logic d2, input logic [5:0] a2);
        in_op_valid[0] = v0; in_op_is_dest[0] = d0; in_op_arn[0] = a0;
        in_op_valid[1] = v1; in_op_is_dest[1] = d1; in_op_arn[1] = a1;
        in_op_valid[2] = v2; in_op_is_dest[2] = d2; in_op_arn[2] = a2;
    endtask

    task automatic clear_freed();
        for (int i = 0; i < c_OPS; i++) begin
            freed_valid[i] = 1'b0;
            freed_prn[i]   = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [c_PRN_BITS-1:0] q[$];
        logic [c_PRN_BITS-1:0] cur;
        logic [c_PRN_BITS-1:0] exp_prn;

        n_checks  = 0;
        n_fail    = 0;
        n_handoff = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_pc     = '0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
        clear_freed();

        // Reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_free_count", free_count, 32);
        check("rst_out_prn0", out_op_prn[0], 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // A: src X1, src X2, dest X3
        set_ops(1, 0, 1, 1, 0, 2, 1, 1, 3);
        in_pc    = 64'h1000;
        in_valid = 1'b1;
        #1;
        check("A_in_ready", in_ready, 1);
        tick();
        check("A_out_valid", out_valid, 1);
        check("A_pc", out_pc, 64'h1000);
        check("A_prn0", out_op_prn[0], 1);
        check("A_prn1", out_op_prn[1], 2);
        check("A_prn2", out_op_prn[2], 32);
        check("A_old_valid0", out_old_valid[0], 0);
        check("A_old_valid1", out_old_valid[1], 0);
        check("A_old_valid2", out_old_valid[2], 1);
        check("A_old_prn2", out_old_prn[2], 3);
        check("A_old_arn2", out_old_arn[2], 3);
        check("A_free_count", free_count, 31);

        // C back-to-back: src X3 sees A's new mapping
        set_ops(1, 0, 3, 0, 0, 0, 0, 0, 0);
        in_pc = 64'h1004;
        tick();
        check("C_out_valid", out_valid, 1);
        check("C_prn0", out_op_prn[0], 32);
        check("C_op_valid1", out_op_valid[1], 0);
        check("C_prn1_unused", out_op_prn[1], 0);
        check("C_old_valid0", out_old_valid[0], 0);

        // D: src X5 and dest X5 in one instruction
        set_ops(1, 0, 5, 1, 1, 5, 0, 0, 0);
        in_pc = 64'h1008;
        tick();
        check("D_src_prn", out_op_prn[0], 5);
        check("D_dest_prn", out_op_prn[1], 33);
        check("D_old_prn", out_old_prn[1], 5);
        check("D_old_arn", out_old_arn[1], 5);
        check("D_old_valid0", out_old_valid[0], 0);
        check("D_old_valid1", out_old_valid[1], 1);
        check("D_free_count", free_count, 30);
        in_valid = 1'b0;
        tick();
        check("D_drained", out_valid, 0);

        // Stall: E accepted, then F held off for 4 cycles
        out_ready = 1'b0;
        set_ops(1, 1, 6, 0, 0, 0, 0, 0, 0);
        in_pc    = 64'h100c;
        in_valid = 1'b1;
        tick();
        check("E_prn", out_op_prn[0], 34);
        check("E_old_prn", out_old_prn[0], 6);
        set_ops(1, 1, 7, 0, 0, 0, 0, 0, 0);
        in_pc = 64'h1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("stall%0d_in_ready", k), in_ready, 0);
            tick();
            check($sformatf("stall%0d_out_valid", k), out_valid, 1);
            check($sformatf("stall%0d_pc", k), out_pc, 64'h100c);
            check($sformatf("stall%0d_prn", k), out_op_prn[0], 34);
            check($sformatf("stall%0d_old_arn", k), out_old_arn[0], 6);
            check($sformatf("stall%0d_free_count", k), free_count, 29);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        check("F_prn", out_op_prn[0], 35);
        check("F_old_prn", out_old_prn[0], 7);
        check("F_pc", out_pc, 64'h1010);
        check("F_free_count", free_count, 28);
        in_valid = 1'b0;
        tick();
        check("F_drained", out_valid, 0);
        check("handoff_count", n_handoff, 5);

        // Exhaust the free list: 9 x three destinations, then one more
        in_valid = 1'b1;
        set_ops(1, 1, 8, 1, 1, 9, 1, 1, 10);
        for (int k = 0; k < 9; k++) begin
            #1;
            check($sformatf("fill%0d_in_ready", k), in_ready, 1);
            tick();
            for (int s = 0; s < 3; s++) begin
                check($sformatf("fill%0d_prn%0d", k, s), out_op_prn[s], 36 + 3 * k + s);
            end
        end
        set_ops(1, 1, 11, 0, 0, 0, 0, 0, 0);
        tick();
        check("last_alloc_prn", out_op_prn[0], 63);
        check("empty_free_count", free_count, 0);

        // Empty list: dest stalls, source-only and zero-register dest still go
        set_ops(1, 1, 12, 0, 0, 0, 0, 0, 0);
        #1;
        check("empty_dest_in_ready", in_ready, 0);
        tick();
        check("empty_dest_no_out", out_valid, 0);
        set_ops(1, 0, 11, 0, 0, 0, 0, 0, 0);
        #1;
        check("empty_src_in_ready", in_ready, 1);
        tick();
        check("empty_src_prn", out_op_prn[0], 63);
        check("empty_src_old_valid", out_old_valid[0], 0);
        set_ops(1, 1, 31, 0, 0, 0, 0, 0, 0);
        #1;
        check("zero_dest_in_ready", in_ready, 1);
        tick();
        check("zero_dest_prn", out_op_prn[0], 31);
        check("zero_dest_old_valid", out_old_valid[0], 0);
        check("zero_dest_free_count", free_count, 0);

        // Free PRN 3 while dest X12 waits; allocatable only next cycle
        set_ops(1, 1, 12, 0, 0, 0, 0, 0, 0);
        freed_valid[0] = 1'b1;
        freed_prn[0]   = 3;
        #1;
        check("free_same_cycle_in_ready", in_ready, 0);
        tick();
        clear_freed();
        check("freed_count", free_count, 1);
        #1;
        check("freed_in_ready", in_ready, 1);
        tick();
        check("realloc_prn", out_op_prn[0], 3);
        check("realloc_old_prn", out_old_prn[0], 12);
        check("realloc_free_count", free_count, 0);

        // Free three, then accept a 2-dest instruction while freeing three more
        in_valid = 1'b0;
        freed_valid[0] = 1'b1; freed_prn[0] = 5;
        freed_valid[1] = 1'b1; freed_prn[1] = 6;
        freed_valid[2] = 1'b1; freed_prn[2] = 7;
        tick();
        check("free3_count", free_count, 3);
        freed_prn[0] = 8; freed_prn[1] = 9; freed_prn[2] = 10;
        set_ops(1, 1, 13, 1, 1, 14, 0, 0, 0);
        in_valid = 1'b1;
        #1;
        check("mix_in_ready", in_ready, 1);
        tick();
        clear_freed();
        check("mix_prn0", out_op_prn[0], 5);
        check("mix_prn1", out_op_prn[1], 6);
        check("mix_old_prn0", out_old_prn[0], 13);
        check("mix_old_prn1", out_old_prn[1], 14);
        check("mix_free_count", free_count, 4);

        // 100 alloc/free rounds on X20; pointers wrap repeatedly
        q   = {6'd7, 6'd8, 6'd9, 6'd10};
        cur = 6'd20;
        set_ops(1, 1, 20, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 100; r++) begin
            freed_valid[0] = 1'b1;
            freed_prn[0]   = cur;
            exp_prn = q.pop_front();
            q.push_back(cur);
            tick();
            check($sformatf("wrap%0d_prn", r), out_op_prn[0], exp_prn);
            check($sformatf("wrap%0d_old_prn", r), out_old_prn[0], cur);
            cur = exp_prn;
        end
        clear_freed();
        in_valid = 1'b0;
        tick();
        check("wrap_free_count", free_count, 4);

        // Reset while stalled with a valid output and a pending instruction
        out_ready = 1'b0;
        set_ops(1, 1, 21, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        tick();
        check("mid_busy", out_valid, 1);
        set_ops(1, 1, 22, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_free_count", free_count, 32);
        check("mid_rst_prn0", out_op_prn[0], 0);
        check("mid_rst_old_valid0", out_old_valid[0], 0);
        out_ready = 1'b1;
        set_ops(1, 0, 3, 1, 0, 20, 1, 1, 21);
        in_valid = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("post_rst_prn0", out_op_prn[0], 3);
        check("post_rst_prn1", out_op_prn[1], 20);
        check("post_rst_prn2", out_op_prn[2], 32);
        check("post_rst_old_prn2", out_old_prn[2], 21);
        check("post_rst_free_count", free_count, 31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
